// File: rtl/back_or_decoder.sv
// Resolves the grouped back-wall OR pattern into candidate bar indices and
// streams them out one index per valid/ready handshake.
module back_or_decoder #(
    parameter int MAX_CAND = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [17:0]      grp_hit,
    input  logic             grp_valid,
    output logic             in_ready,
    output logic [27:0]      bar_mask,
    output logic [4:0]       bar_idx,
    output logic             bar_valid,
    output logic             bar_last,
    input  logic             out_ready,
    output logic             bar_none,
    output logic             trunc,
    output logic [CNT_W-1:0] evt_cnt
);
    localparam int EW = $clog2(MAX_CAND + 1);

    localparam int LO [0:17] = '{0, 1, 2, 4, 5, 6, 8, 9, 11, 12, 13, 15, 16, 17, 19, 20, 21, 23};
    localparam int HI [0:17] = '{4, 6, 7, 8, 10, 11, 12, 14, 15, 16, 18, 19, 21, 22, 23, 25, 26, 27};

    typedef enum logic [1:0] {IDLE, DECODE, EMIT} state_t;

    // A bar survives only if no group covering it is missing.
    function automatic logic [27:0] decode_cand(input logic [17:0] hit);
        logic [27:0] c;
        c = '1;
        for (int g = 0; g < 18; g++) begin
            for (int b = 0; b < 28; b++) begin
                if (b >= LO[g] && b <= HI[g] && !hit[g]) c[b] = 1'b0;
            end
        end
        return c;
    endfunction

    function automatic logic [4:0] lowest_bit(input logic [27:0] m);
        logic [4:0] idx;
        idx = '0;
        for (int b = 27; b >= 0; b--) begin
            if (m[b]) idx = 5'(b);
        end
        return idx;
    endfunction

    state_t           state_q, state_d;
    logic [17:0]      hit_q, hit_d;
    logic [27:0]      mask_q, mask_d;
    logic [27:0]      work_q, work_d;
    logic [EW-1:0]    emit_q, emit_d;
    logic [4:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             none_q, none_d;
    logic             trunc_q, trunc_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] evt_q, evt_d;

    logic [27:0]      cand;
    logic [27:0]      work_n;
    logic [EW-1:0]    emit_n;
    logic             hs;

    assign cand = decode_cand(hit_q);
    assign hs   = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        mask_d  = mask_q;
        work_d  = work_q;
        emit_d  = emit_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        none_d  = 1'b0;
        trunc_d = trunc_q;
        rdy_d   = rdy_q;
        evt_d   = evt_q;
        work_n  = hs ? (work_q & ~(28'd1 << idx_q)) : work_q;
        emit_n  = hs ? (emit_q + EW'(1)) : emit_q;
        case (state_q)
            IDLE: begin
                if (grp_valid) begin
                    hit_d   = grp_hit;
                    evt_d   = evt_q + CNT_W'(1);
                    rdy_d   = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                mask_d  = cand;
                work_d  = cand;
                emit_d  = '0;
                trunc_d = 1'b0;
                if (cand == '0) begin
                    none_d  = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                work_d = work_n;
                emit_d = emit_n;
                if (hs && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    trunc_d = (work_n != '0);
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end else if (!valid_q || hs) begin
                    // Present the next index; the first beat loads from the freshly decoded mask.
                    valid_d = 1'b1;
                    idx_d   = lowest_bit(work_n);
                    last_d  = ((work_n & (work_n - 28'd1)) == '0) ||
                              (emit_n == EW'(MAX_CAND - 1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hit_q   <= '0;
            mask_q  <= '0;
            work_q  <= '0;
            emit_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            none_q  <= 1'b0;
            trunc_q <= 1'b0;
            rdy_q   <= 1'b1;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            mask_q  <= mask_d;
            work_q  <= work_d;
            emit_q  <= emit_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            none_q  <= none_d;
            trunc_q <= trunc_d;
            rdy_q   <= rdy_d;
            evt_q   <= evt_d;
        end
    end

    assign in_ready  = rdy_q;
    assign bar_mask  = mask_q;
    assign bar_idx   = idx_q;
    assign bar_valid = valid_q;
    assign bar_last  = last_q;
    assign bar_none  = none_q;
    assign trunc     = trunc_q;
    assign evt_cnt   = evt_q;
endmodule

// File: tb/tb_back_or_decoder.sv
// Directed bench for back_or_decoder with hand-computed candidate masks.
module tb_back_or_decoder;
    logic        clk;
    logic        reset;
    logic [17:0] grp_hit;
    logic        grp_valid;
    logic        in_ready;
    logic [27:0] bar_mask;
    logic [4:0]  bar_idx;
    logic        bar_valid;
    logic        bar_last;
    logic        out_ready;
    logic        bar_none;
    logic        trunc;
    logic [15:0] evt_cnt;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_evt;

    back_or_decoder #(.MAX_CAND(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .grp_hit(grp_hit), .grp_valid(grp_valid),
        .in_ready(in_ready), .bar_mask(bar_mask), .bar_idx(bar_idx),
        .bar_valid(bar_valid), .bar_last(bar_last), .out_ready(out_ready),
        .bar_none(bar_none), .trunc(trunc), .evt_cnt(evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [17:0] h);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        grp_hit   = h;
        grp_valid = 1'b1;
        step();
        grp_valid = 1'b0;
        exp_evt   = exp_evt + 16'd1;
        chk("evt_cnt", 32'(evt_cnt), 32'(exp_evt));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
    endtask

    // Sends a pattern with out_ready high and checks every emitted index against emask.
    task automatic run_pattern(input logic [17:0] h, input logic [27:0] emask, input logic etrunc);
        int  k;
        int  p;
        int  t;
        logic done;
        logic rem;
        send(h);
        step();
        chk("bar_mask", 32'(bar_mask), 32'(emask));
        if (emask == '0) begin
            chk("bar_none_pulse", 32'(bar_none), 32'd1);
            chk("no_valid_none", 32'(bar_valid), 32'd0);
            step();
            chk("bar_none_end", 32'(bar_none), 32'd0);
            chk("in_ready_after_none", 32'(in_ready), 32'd1);
            return;
        end
        chk("bar_none_low", 32'(bar_none), 32'd0);
        chk("valid_before_first", 32'(bar_valid), 32'd0);
        step();
        k = 0; p = 0; t = 0; done = 1'b0;
        while (!done && t < 40) begin
            if (bar_valid) begin
                while (p < 28 && !emask[p]) p++;
                rem = ((emask >> (p + 1)) != '0);
                chk("bar_idx", 32'(bar_idx), 32'(p));
                chk("bar_last", 32'(bar_last), 32'((k == 7) || !rem));
                if (bar_last) done = 1'b1;
                p++;
                k++;
            end else begin
                chk("bar_valid_gap", 32'(bar_valid), 32'd1);
            end
            step();
            t++;
        end
        chk("emit_done", 32'(done), 32'd1);
        chk("valid_after_last", 32'(bar_valid), 32'd0);
        chk("in_ready_after_last", 32'(in_ready), 32'd1);
        chk("trunc", 32'(trunc), 32'(etrunc));
        chk("mask_hold", 32'(bar_mask), 32'(emask));
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_evt = '0;
        reset = 1'b1; grp_hit = '0; grp_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mask", 32'(bar_mask), 32'd0);
        chk("rst_valid", 32'(bar_valid), 32'd0);
        chk("rst_evt", 32'(evt_cnt), 32'd0);
        reset = 1'b0;
        step();

        run_pattern(18'h00001, 28'h0000001, 1'b0);
        run_pattern(18'h000F0, 28'h0000600, 1'b0);
        run_pattern(18'h00000, 28'h0000000, 1'b0);
        chk("evt_after_none", 32'(evt_cnt), 32'd3);

        // Stall on the first beat; stray grp_valid while busy must be ignored.
        out_ready = 1'b0;
        send(18'h20001);
        step();
        chk("bar_mask_ends", 32'(bar_mask), 32'h8000001);
        grp_valid = 1'b1;
        grp_hit   = 18'h3FFFF;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(bar_valid), 32'd1);
            chk("stall_idx", 32'(bar_idx), 32'd0);
            chk("stall_last", 32'(bar_last), 32'd0);
            if (i < 2) step();
        end
        grp_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("second_idx", 32'(bar_idx), 32'd27);
        chk("second_last", 32'(bar_last), 32'd1);
        chk("second_valid", 32'(bar_valid), 32'd1);
        step();
        chk("ends_done", 32'(bar_valid), 32'd0);
        chk("evt_ignored", 32'(evt_cnt), 32'(exp_evt));
        chk("ends_trunc", 32'(trunc), 32'd0);

        run_pattern(18'h3FFFF, 28'hFFFFFFF, 1'b1);

        // Reset in the middle of emission.
        send(18'h3FFFF);
        step();
        step();
        chk("pre_rst_idx0", 32'(bar_idx), 32'd0);
        step();
        step();
        chk("pre_rst_idx2", 32'(bar_idx), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bar_valid), 32'd0);
        chk("mid_rst_idx", 32'(bar_idx), 32'd0);
        chk("mid_rst_mask", 32'(bar_mask), 32'd0);
        chk("mid_rst_evt", 32'(evt_cnt), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_trunc", 32'(trunc), 32'd0);
        exp_evt = '0;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_valid", 32'(bar_valid), 32'd0);
        run_pattern(18'h20000, 28'h8000000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
